// File: rtl/multicycle_sequencer.sv
// Multi-cycle control FSM: fetch over req/ack, decode into ALU controls, iterative shifts.
// Optional retired-instruction counter enabled by defining PERF_CNT_EN.
module multicycle_sequencer #(
  parameter int TIMEOUT = 16,
  parameter int SHAMT_W = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        run,
  output logic        imem_req,
  input  logic        imem_ack,
  input  logic [31:0] instr,
  output logic        ir_load,
  output logic        pc_inc,
  output logic [3:0]  alu_op,
  output logic        imm_sel,
  output logic        shift_step,
  output logic        reg_we,
  output logic        busy,
  output logic        trap,
  output logic [1:0]  trap_code,
  output logic [31:0] instr_ret
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_SHIFT, S_WB, S_TRAP
  } state_t;

  localparam int WAIT_W = $clog2(TIMEOUT + 1);

  state_t             state, state_nxt;
  logic [WAIT_W-1:0]  wait_cnt;
  logic [SHAMT_W-1:0] cnt;
  logic [31:0]        ir;
  logic               is_shift;
  logic [3:0]         dec_alu;
  logic               dec_imm;
  logic [1:0]         dec_err;
  logic               fetch_expired;
  logic [SHAMT_W-1:0] ir_shamt;
  logic               unused_ir;

  // Handshake: imem_req is held for the whole of FETCH; a cycle with
  // imem_req & imem_ack transfers instr. imem_ack in any other state is ignored.
  assign imem_req   = (state == S_FETCH);
  assign ir_load    = (state == S_FETCH) && imem_ack;
  assign pc_inc     = ir_load;
  assign shift_step = (state == S_SHIFT);
  assign reg_we     = (state == S_WB);
  assign trap       = (state == S_TRAP);
  assign busy       = (state != S_IDLE) && (state != S_TRAP);

  assign ir_shamt      = ir[6 +: SHAMT_W];
  assign fetch_expired = (wait_cnt == WAIT_W'(TIMEOUT - 1)) && !imem_ack;
  assign unused_ir     = ^ir;

  // dec_err carries the trap code directly; 00 means the instruction is legal.
  always_comb begin
    dec_alu = 4'b0000;
    dec_imm = 1'b0;
    dec_err = 2'b00;
    if (ir[31:26] == 6'h3F) begin
      dec_imm = 1'b1;
    end else if (ir[31:26] == 6'h00) begin
      case (ir[5:0])
        6'h00:   dec_alu = 4'b1001;
        6'h02:   dec_alu = 4'b1010;
        6'h20:   dec_alu = 4'b0010;
        6'h22:   dec_alu = 4'b0110;
        6'h24:   dec_alu = 4'b0000;
        6'h25:   dec_alu = 4'b0001;
        default: dec_err = 2'b11;
      endcase
    end else begin
      dec_err = 2'b10;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (run) state_nxt = S_FETCH;
      S_FETCH: begin
        if (imem_ack)           state_nxt = S_DECODE;
        else if (fetch_expired) state_nxt = S_TRAP;
      end
      S_DECODE: state_nxt = (dec_err != 2'b00) ? S_TRAP : S_EXEC;
      S_EXEC:   state_nxt = (is_shift && ir_shamt != '0) ? S_SHIFT : S_WB;
      S_SHIFT:  if (cnt == SHAMT_W'(1)) state_nxt = S_WB;
      S_WB:     state_nxt = run ? S_FETCH : S_IDLE;
      S_TRAP:   state_nxt = S_TRAP;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      wait_cnt  <= '0;
      cnt       <= '0;
      ir        <= '0;
      is_shift  <= 1'b0;
      alu_op    <= 4'b0000;
      imm_sel   <= 1'b0;
      trap_code <= 2'b00;
    end else begin
      state    <= state_nxt;
      wait_cnt <= (state == S_FETCH) ? wait_cnt + 1'b1 : '0;
      if (ir_load) ir <= instr;
      if (state == S_DECODE) begin
        if (dec_err == 2'b00) begin
          alu_op   <= dec_alu;
          imm_sel  <= dec_imm;
          is_shift <= dec_alu[3];
        end else begin
          trap_code <= dec_err;
        end
      end
      if (state == S_FETCH && fetch_expired) trap_code <= 2'b01;
      if (state == S_EXEC)       cnt <= ir_shamt;
      else if (state == S_SHIFT) cnt <= cnt - 1'b1;
    end
  end

`ifdef PERF_CNT_EN
  logic [31:0] ret_cnt;
  always_ff @(posedge clk) begin
    if (rst)                ret_cnt <= '0;
    else if (state == S_WB) ret_cnt <= ret_cnt + 32'd1;
  end
  assign instr_ret = ret_cnt;
`else
  assign instr_ret = 32'h0;
`endif

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Bench for multicycle_sequencer: fetch responder pushes expected decode results,
// a negedge monitor pops them on every reg_we.
module tb_multicycle_sequencer;

  logic        clk = 1'b0;
  logic        rst, run, imem_ack;
  logic [31:0] instr;
  logic        imem_req, ir_load, pc_inc, imm_sel, shift_step, reg_we, busy, trap;
  logic [3:0]  alu_op;
  logic [1:0]  trap_code;
  logic [31:0] instr_ret;

  int checks = 0;
  int errors = 0;
  logic [23:0] exp_q[$];   // {latency[7:0], steps[7:0], 3'b0, imm_sel, alu_op[3:0]}
  logic [31:0] exp_ret = 0;

  multicycle_sequencer #(.TIMEOUT(16), .SHAMT_W(5)) dut (
    .clk(clk), .rst(rst), .run(run), .imem_req(imem_req), .imem_ack(imem_ack),
    .instr(instr), .ir_load(ir_load), .pc_inc(pc_inc), .alu_op(alu_op),
    .imm_sel(imm_sel), .shift_step(shift_step), .reg_we(reg_we), .busy(busy),
    .trap(trap), .trap_code(trap_code), .instr_ret(instr_ret)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, want);
    end
  endtask

  function automatic logic [31:0] rtype(input logic [5:0] fn, input logic [4:0] shamt);
    return {6'h00, 5'd1, 5'd2, 5'd3, shamt, fn};
  endfunction

  // Reference decode table.
  function automatic logic [23:0] model(input logic [31:0] w);
    logic [3:0] alu;
    logic       imm;
    logic [7:0] steps;
    alu = 4'b0000; imm = 1'b0; steps = 8'd0;
    if (w[31:26] == 6'h3F) imm = 1'b1;
    else begin
      case (w[5:0])
        6'h00: begin alu = 4'b1001; steps = {3'b0, w[10:6]}; end
        6'h02: begin alu = 4'b1010; steps = {3'b0, w[10:6]}; end
        6'h20: alu = 4'b0010;
        6'h22: alu = 4'b0110;
        6'h24: alu = 4'b0000;
        default: alu = 4'b0001;
      endcase
    end
    return {8'd3 + steps, steps, 3'b000, imm, alu};
  endfunction

  task automatic do_reset();
    rst = 1'b1; run = 1'b0; imem_ack = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    exp_ret = 0;
  endtask

  // Wait for a fetch, withhold ack for delay cycles, then present w for one cycle.
  task automatic serve(input logic [31:0] w, input int delay, input bit legal);
    int n = 0;
    while (!imem_req && n < 80) begin
      @(posedge clk); #1; n++;
    end
    if (!imem_req) begin
      check("fetch_req_wait", 32'(imem_req), 32'd1);
      return;
    end
    repeat (delay) begin
      @(posedge clk); #1;
    end
    instr = w; imem_ack = 1'b1;
    if (legal) begin
      exp_q.push_back(model(w));
      exp_ret++;
    end
    #1 check("ir_load_pc_inc", {30'b0, ir_load, pc_inc}, 32'd3);
    @(posedge clk); #1;
    imem_ack = 1'b0; instr = $urandom;
  endtask

  task automatic drain();
    int n = 0;
    while (busy && n < 100) begin
      @(posedge clk); #1; n++;
    end
    check("drain_idle", 32'(busy), 32'd0);
    check("queue_empty", exp_q.size(), 32'd0);
  endtask

  function automatic logic [31:0] ret_model();
`ifdef PERF_CNT_EN
    return exp_ret;
`else
    return 32'h0;
`endif
  endfunction

  // Monitor: latency and shift steps measured from the accepted fetch.
  int cyc = 0, ack_cyc = 0, steps = 0;
  always @(negedge clk) begin
    logic [23:0] e;
    cyc++;
    if (rst) steps = 0;
    else begin
      if (imem_req && imem_ack) begin ack_cyc = cyc; steps = 0; end
      if (shift_step) steps++;
      if (reg_we) begin
        if (exp_q.size() == 0) check("unexpected_reg_we", 32'd1, 32'd0);
        else begin
          e = exp_q.pop_front();
          check("alu_op", 32'(alu_op), 32'(e[3:0]));
          check("imm_sel", 32'(imm_sel), 32'(e[4]));
          check("shift_steps", steps, 32'(e[15:8]));
          check("wb_latency", cyc - ack_cyc, 32'(e[23:16]));
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout");
    $fatal(1, "bench timeout");
  end

  initial begin
    logic [5:0] fns [6];
    logic [31:0] w;
    int n;
    fns = '{6'h00, 6'h02, 6'h20, 6'h22, 6'h24, 6'h25};
    rst = 1'b1; run = 1'b0; imem_ack = 1'b0; instr = '0;
    do_reset();
    check("rst_imem_req", 32'(imem_req), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_trap", {29'b0, trap, trap_code}, 32'd0);
    check("rst_alu_imm", {27'b0, imm_sel, alu_op}, 32'd0);
    check("rst_strobes", {28'b0, reg_we, shift_step, ir_load, pc_inc}, 32'd0);
    check("rst_instr_ret", instr_ret, 32'd0);

    // Directed programme, including ack on the last cycle before timeout.
    run = 1'b1;
    serve({6'h3F, 26'h0123456}, 1, 1'b1);
    serve(rtype(6'h22, 5'd0), 0, 1'b1);
    serve(rtype(6'h20, 5'd7), 2, 1'b1);
    serve(rtype(6'h24, 5'd0), 0, 1'b1);
    serve(rtype(6'h25, 5'd0), 3, 1'b1);
    serve(rtype(6'h00, 5'd5), 0, 1'b1);
    serve(rtype(6'h00, 5'd0), 1, 1'b1);
    serve(rtype(6'h02, 5'd3), 0, 1'b1);
    serve(rtype(6'h00, 5'd31), 0, 1'b1);
    serve({6'h3F, 26'h3FFFFFF}, 15, 1'b1);
    for (int i = 0; i < 12; i++) begin
      if ($urandom_range(0, 4) == 0) w = {6'h3F, 26'($urandom)};
      else w = rtype(fns[$urandom_range(0, 5)], 5'($urandom_range(0, 31)));
      serve(w, $urandom_range(0, 15), 1'b1);
    end
    run = 1'b0;
    drain();
    check("instr_ret_main", instr_ret, ret_model());

    // Fetch timeout: 16 cycles of FETCH then sticky TRAP.
    do_reset();
    run = 1'b1;
    n = 0;
    while (!imem_req && n < 10) begin @(posedge clk); #1; n++; end
    repeat (15) begin @(posedge clk); #1; end
    check("fetch_cycle16_req", {31'b0, imem_req}, 32'd1);
    check("fetch_cycle16_trap", {31'b0, trap}, 32'd0);
    @(posedge clk); #1;
    check("timeout_trap", {31'b0, trap}, 32'd1);
    check("timeout_code", {30'b0, trap_code}, 32'd1);
    check("timeout_req", {30'b0, imem_req, busy}, 32'd0);
    imem_ack = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    check("trap_ack_ignored", {31'b0, ir_load}, 32'd0);
    imem_ack = 1'b0;
    repeat (5) begin @(posedge clk); #1; end
    check("trap_sticky", {29'b0, trap, trap_code}, 32'd5);

    // Illegal opcode and illegal funct.
    do_reset();
    check("rst_clears_trap", {29'b0, trap, trap_code}, 32'd0);
    run = 1'b1;
    serve({6'h08, 26'h0}, 2, 1'b0);
    repeat (3) begin @(posedge clk); #1; end
    check("illegal_op", {29'b0, trap, trap_code}, 32'd6);
    do_reset();
    run = 1'b1;
    serve(rtype(6'h3F, 5'd0), 0, 1'b0);
    repeat (3) begin @(posedge clk); #1; end
    check("illegal_fn", {29'b0, trap, trap_code}, 32'd7);

    // Reset in the middle of a shift (counter at 3).
    do_reset();
    run = 1'b1;
    serve(rtype(6'h00, 5'd5), 0, 1'b0);
    n = 0;
    while (!shift_step && n < 10) begin @(posedge clk); #1; n++; end
    check("shift_started", {31'b0, shift_step}, 32'd1);
    repeat (2) begin @(posedge clk); #1; end
    rst = 1'b1; run = 1'b0;
    @(posedge clk); #1;
    check("midshift_rst_idle", {29'b0, busy, imem_req, shift_step}, 32'd0);
    check("midshift_rst_alu", {27'b0, imm_sel, alu_op}, 32'd0);
    rst = 1'b0;
    repeat (5) begin @(posedge clk); #1; end
    check("after_rst_idle", {31'b0, busy}, 32'd0);

    // Retired-instruction count over four instructions, then reset.
    run = 1'b1;
    serve(rtype(6'h20, 5'd0), 0, 1'b1);
    serve(rtype(6'h02, 5'd2), 1, 1'b1);
    serve({6'h3F, 26'h0}, 0, 1'b1);
    serve(rtype(6'h22, 5'd0), 0, 1'b1);
    run = 1'b0;
    drain();
    check("instr_ret_four", instr_ret, ret_model());
    do_reset();
    check("instr_ret_rst", instr_ret, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
